mips_muldiv_unit: RTL and testbench

//   Iterative multiply/divide unit with architectural HI/LO registers.

---
 rtl/mips_muldiv_unit_if.sv | 33 +++
 rtl/mips_muldiv_unit.sv | 206 ++++++++++++++++++++
 tb/tb_mips_muldiv_unit.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_muldiv_unit_if.sv
// mips_muldiv_unit_if
//   Operand/result bundle between the issue stage and the MIPS multiply/divide
//   unit.
//   master : drives start/op/operands and MTHI/MTLO writes, observes status and HI/LO
//   slave  : the muldiv unit itself
//   Signals: start, op[1:0], operand_a, operand_b, hi_write, lo_write, write_data
//            (master -> slave); busy, done, div_by_zero, hi, lo (slave -> master)
interface mips_muldiv_unit_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] operand_a;
   logic [WIDTH-1:0] operand_b;
   logic             hi_write;
   logic             lo_write;
   logic [WIDTH-1:0] write_data;
   logic             busy;
   logic             done;
   logic             div_by_zero;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output start, op, operand_a, operand_b, hi_write, lo_write, write_data,
      input  busy, done, div_by_zero, hi, lo
   );

   modport slave (
      input  start, op, operand_a, operand_b, hi_write, lo_write, write_data,
      output busy, done, div_by_zero, hi, lo
   );
endinterface

// File: rtl/mips_muldiv_unit.sv
// mips_muldiv_unit
//   Iterative multiply/divide unit holding the architectural HI/LO registers.
//   Radix-2 shift-add multiply and restoring divide, one bit per clock.
//   Every op takes WIDTH+1 edges from the start edge to done (WIDTH RUN
//   iterations plus one FIX edge that applies signs and writes HI/LO).
//   Ports:
//     clk  - clock, all state on posedge
//     rst  - synchronous reset, active high
//     bus  - mips_muldiv_unit_if.slave (start/op/operands, MTHI/MTLO writes,
//            busy/done/div_by_zero status, HI/LO read-out)
//   op encoding: 00 MULTU, 01 DIVU, 10 MULT, 11 DIV
//   Configuration macro MULDIV_SIGNED_EN: when defined, op[1] selects signed
//   MULT/DIV; when undefined all ops are unsigned and op[1] is ignored.
module mips_muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   mips_muldiv_unit_if.slave     bus
);
   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_e;

   state_e             state_q,  state_d;
   logic [CW-1:0]      cnt_q,    cnt_d;
   logic               is_div_q, is_div_d;
   logic               b_zero_q, b_zero_d;
   // Multiplicand (multiply) or divisor (divide) magnitude.
   logic [WIDTH-1:0]   opnd_q,   opnd_d;
   // Multiply: {partial product, remaining multiplier bits}.
   // Divide:   {partial remainder, remaining dividend bits / quotient bits}.
   logic [2*WIDTH-1:0] acc_q,    acc_d;
   logic               busy_q,   busy_d;
   logic               done_q,   done_d;
   logic               dbz_q,    dbz_d;
   logic [WIDTH-1:0]   hi_q,     hi_d;
   logic [WIDTH-1:0]   lo_q,     lo_d;
`ifdef MULDIV_SIGNED_EN
   logic               neg_res_q, neg_res_d;
   logic               neg_rem_q, neg_rem_d;
   logic               neg_a, neg_b;
`else
   logic               unused_op_sign;
`endif

   logic [WIDTH-1:0]   mag_a, mag_b;
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_next;
   logic [WIDTH:0]     div_shift;
   logic               div_lt;
   logic [WIDTH-1:0]   div_sub;
   logic [2*WIDTH-1:0] div_next;
   logic [WIDTH-1:0]   res_hi, res_lo;

   // Operand magnitudes captured at start; signs are reapplied in FIX.
   always_comb begin
`ifdef MULDIV_SIGNED_EN
      neg_a = bus.op[1] & bus.operand_a[WIDTH-1];
      neg_b = bus.op[1] & bus.operand_b[WIDTH-1];
      mag_a = neg_a ? -bus.operand_a : bus.operand_a;
      mag_b = neg_b ? -bus.operand_b : bus.operand_b;
`else
      unused_op_sign = bus.op[1];
      mag_a = bus.operand_a;
      mag_b = bus.operand_b;
`endif
   end

   // One iteration of each algorithm.
   always_comb begin
      // Shift-add: add multiplicand when the current multiplier LSB is set,
      // then shift the whole accumulator right; the carry lands in the MSB.
      mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
               + (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
      mul_next = {mul_sum, acc_q[WIDTH-1:1]};
      // Restoring divide: shift the next dividend bit into the remainder,
      // subtract the divisor if it fits. A partial remainder below the divisor
      // fits in WIDTH bits, so the WIDTH-bit subtraction is exact.
      div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
      div_lt    = div_shift < {1'b0, opnd_q};
      div_sub   = div_shift[WIDTH-1:0] - opnd_q;
      div_next  = {(div_lt ? div_shift[WIDTH-1:0] : div_sub), acc_q[WIDTH-2:0], ~div_lt};
   end

   // Final HI/LO from the accumulator. A zero divisor naturally leaves the
   // dividend in the remainder and all ones in the quotient magnitude; the
   // quotient is forced to all ones so a sign flip cannot alter it.
   always_comb begin
      res_hi = acc_q[2*WIDTH-1:WIDTH];
      res_lo = acc_q[WIDTH-1:0];
`ifdef MULDIV_SIGNED_EN
      if (!is_div_q) begin
         if (neg_res_q) {res_hi, res_lo} = -acc_q;
      end else begin
         if (neg_res_q) res_lo = -acc_q[WIDTH-1:0];
         if (neg_rem_q) res_hi = -acc_q[2*WIDTH-1:WIDTH];
      end
`endif
      if (is_div_q && b_zero_q) res_lo = {WIDTH{1'b1}};
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      is_div_d = is_div_q;
      b_zero_d = b_zero_q;
      opnd_d   = opnd_q;
      acc_d    = acc_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      dbz_d    = 1'b0;
      hi_d     = hi_q;
      lo_d     = lo_q;
`ifdef MULDIV_SIGNED_EN
      neg_res_d = neg_res_q;
      neg_rem_d = neg_rem_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               // start takes priority; a same-cycle MTHI/MTLO is dropped.
               state_d  = S_RUN;
               cnt_d    = '0;
               busy_d   = 1'b1;
               is_div_d = bus.op[0];
               b_zero_d = (bus.operand_b == '0);
               if (bus.op[0]) begin
                  opnd_d = mag_b;
                  acc_d  = {{WIDTH{1'b0}}, mag_a};
               end else begin
                  opnd_d = mag_a;
                  acc_d  = {{WIDTH{1'b0}}, mag_b};
               end
`ifdef MULDIV_SIGNED_EN
               neg_res_d = neg_a ^ neg_b;
               neg_rem_d = neg_a;
`endif
            end else begin
               if (bus.hi_write) hi_d = bus.write_data;
               if (bus.lo_write) lo_d = bus.write_data;
            end
         end
         S_RUN: begin
            acc_d = is_div_q ? div_next : mul_next;
            if (cnt_q == CW'(WIDTH-1)) begin
               state_d = S_FIX;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_FIX: begin
            hi_d    = res_hi;
            lo_d    = res_lo;
            done_d  = 1'b1;
            dbz_d   = is_div_q & b_zero_q;
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         is_div_q <= 1'b0;
         b_zero_q <= 1'b0;
         opnd_q   <= '0;
         acc_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         dbz_q    <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
`ifdef MULDIV_SIGNED_EN
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         is_div_q <= is_div_d;
         b_zero_q <= b_zero_d;
         opnd_q   <= opnd_d;
         acc_q    <= acc_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         dbz_q    <= dbz_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
`ifdef MULDIV_SIGNED_EN
         neg_res_q <= neg_res_d;
         neg_rem_q <= neg_rem_d;
`endif
      end
   end

   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.div_by_zero = dbz_q;
   assign bus.hi          = hi_q;
   assign bus.lo          = lo_q;
endmodule

// File: tb/tb_mips_muldiv_unit.sv
// tb_mips_muldiv_unit
//   Randomized + directed bench for mips_muldiv_unit. Expected HI/LO/div_by_zero
//   and done cycle are pushed to a queue at issue; a monitor pops on done.
//   Honours MULDIV_SIGNED_EN the same way as the design.
`timescale 1ns/1ps
module tb_mips_muldiv_unit;
   localparam int W = 32;

   typedef struct {
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      logic         dbz;
      int unsigned  cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   mips_muldiv_unit_if #(.WIDTH(W)) bus();
   mips_muldiv_unit #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

   exp_t         sb_q[$];
   exp_t         mon_e;
   int           checks = 0;
   int           errors = 0;
   int unsigned  cyc = 0;
   logic [W-1:0] m_hi = '0;
   logic [W-1:0] m_lo = '0;
   logic         prev_done = 1'b0;

   always @(posedge clk) cyc++;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: plain arithmetic on the architectural definition.
   function automatic exp_t model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t        e;
      logic        sgn;
      longint      sp;
      logic [63:0] up;
      int          sa, sb;
`ifdef MULDIV_SIGNED_EN
      sgn = op[1];
`else
      sgn = 1'b0;
`endif
      e.dbz = 1'b0;
      e.cyc = 0;
      if (!op[0]) begin
         if (sgn) begin
            sp = longint'($signed(a)) * longint'($signed(b));
            {e.hi, e.lo} = sp;
         end else begin
            up = {32'd0, a} * {32'd0, b};
            {e.hi, e.lo} = up;
         end
      end else if (b == '0) begin
         e.hi = a; e.lo = '1; e.dbz = 1'b1;
      end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         e.lo = a; e.hi = '0;
      end else if (sgn) begin
         sa = a; sb = b;
         e.lo = sa / sb;
         e.hi = sa % sb;
      end else begin
         e.lo = a / b;
         e.hi = a % b;
      end
      return e;
   endfunction

   // Monitor: compare every done pulse against the head of the scoreboard.
   always @(negedge clk) begin
      if (prev_done) chk("done_width", {63'd0, bus.done}, 64'd0);
      if (bus.done) begin
         if (sb_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_done actual=1 expected=0 (cycle %0d)", cyc);
         end else begin
            mon_e = sb_q.pop_front();
            chk("hi",        {32'd0, bus.hi}, {32'd0, mon_e.hi});
            chk("lo",        {32'd0, bus.lo}, {32'd0, mon_e.lo});
            chk("dbz",       {63'd0, bus.div_by_zero}, {63'd0, mon_e.dbz});
            chk("latency",   {32'd0, cyc}, {32'd0, mon_e.cyc});
         end
      end else if (bus.div_by_zero) begin
         checks++; errors++;
         $display("FAIL dbz_without_done actual=1 expected=0 (cycle %0d)", cyc);
      end
      prev_done = bus.done;
   end

   task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic wr_lo, input logic expect_done);
      exp_t         e;
      logic [W-1:0] old_hi, old_lo;
      @(negedge clk);
      old_hi = bus.hi; old_lo = bus.lo;
      bus.start = 1'b1; bus.op = op; bus.operand_a = a; bus.operand_b = b;
      bus.lo_write = wr_lo; bus.write_data = 32'hDEAD_BEEF;
      if (expect_done) begin
         e = model(op, a, b);
         e.cyc = cyc + 34;
         sb_q.push_back(e);
         m_hi = e.hi; m_lo = e.lo;
      end
      @(negedge clk);
      bus.start = 1'b0; bus.lo_write = 1'b0;
      chk("busy_after_start", {63'd0, bus.busy}, 64'd1);
      chk("hi_hold_busy", {32'd0, bus.hi}, {32'd0, old_hi});
      chk("lo_hold_busy", {32'd0, bus.lo}, {32'd0, old_lo});
   endtask

   task automatic wait_done();
      int n = 0;
      while (!bus.done && n < 60) begin
         @(negedge clk);
         n++;
      end
      chk("done_timeout", {63'd0, bus.done}, 64'd1);
      @(negedge clk);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0]   rop;
      logic [W-1:0] ra, rb;
      rst = 1'b1;
      bus.start = 1'b0; bus.op = 2'b00; bus.operand_a = '0; bus.operand_b = '0;
      bus.hi_write = 1'b0; bus.lo_write = 1'b0; bus.write_data = '0;
      repeat (3) @(negedge clk);
      chk("rst_busy", {63'd0, bus.busy}, 64'd0);
      chk("rst_done", {63'd0, bus.done}, 64'd0);
      chk("rst_dbz",  {63'd0, bus.div_by_zero}, 64'd0);
      chk("rst_hi",   {32'd0, bus.hi}, 64'd0);
      chk("rst_lo",   {32'd0, bus.lo}, 64'd0);
      rst = 1'b0;

      // Full-range unsigned multiply and its fixed latency.
      issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1);
      wait_done();

      // Reset in the middle of RUN: nothing completes, HI/LO cleared.
      issue(2'b00, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b0);
      repeat (10) @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("midrst_busy", {63'd0, bus.busy}, 64'd0);
      chk("midrst_hi",   {32'd0, bus.hi}, 64'd0);
      chk("midrst_lo",   {32'd0, bus.lo}, 64'd0);
      m_hi = '0; m_lo = '0;
      repeat (45) @(negedge clk);

      // DIVU 100/7 with a stray start and MTHI while busy.
      issue(2'b01, 32'd100, 32'd7, 1'b0, 1'b1);
      repeat (3) @(negedge clk);
      bus.start = 1'b1; bus.op = 2'b00; bus.operand_a = 32'd5; bus.operand_b = 32'd5;
      bus.hi_write = 1'b1; bus.write_data = 32'h1111_1111;
      @(negedge clk);
      bus.start = 1'b0; bus.hi_write = 1'b0;
      chk("busy_ignore_start", {63'd0, bus.busy}, 64'd1);
      wait_done();

      // Divide by zero.
      issue(2'b01, 32'h0000_1234, 32'h0, 1'b0, 1'b1);
      wait_done();

      // Signed forms (act as unsigned when the feature is compiled out).
      issue(2'b10, 32'hFFFF_FFFD, 32'd5, 1'b0, 1'b1);
      wait_done();
      issue(2'b11, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b1);
      wait_done();
      issue(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1);
      wait_done();
      issue(2'b11, 32'hFFFF_FFF9, 32'h0, 1'b0, 1'b1);
      wait_done();

      // MTLO / MTHI / both.
      @(negedge clk);
      bus.lo_write = 1'b1; bus.write_data = 32'hA5A5_A5A5;
      @(negedge clk);
      bus.lo_write = 1'b0;
      m_lo = 32'hA5A5_A5A5;
      chk("mtlo_lo", {32'd0, bus.lo}, {32'd0, m_lo});
      chk("mtlo_hi", {32'd0, bus.hi}, {32'd0, m_hi});
      bus.hi_write = 1'b1; bus.write_data = 32'h0F0F_0F0F;
      @(negedge clk);
      bus.hi_write = 1'b0;
      m_hi = 32'h0F0F_0F0F;
      chk("mthi_hi", {32'd0, bus.hi}, {32'd0, m_hi});
      chk("mthi_lo", {32'd0, bus.lo}, {32'd0, m_lo});
      bus.hi_write = 1'b1; bus.lo_write = 1'b1; bus.write_data = 32'h5A5A_1234;
      @(negedge clk);
      bus.hi_write = 1'b0; bus.lo_write = 1'b0;
      m_hi = 32'h5A5A_1234; m_lo = 32'h5A5A_1234;
      chk("mtboth_hi", {32'd0, bus.hi}, {32'd0, m_hi});
      chk("mtboth_lo", {32'd0, bus.lo}, {32'd0, m_lo});

      // start and MTLO in the same cycle: the write is dropped.
      issue(2'b01, 32'd1000, 32'd33, 1'b1, 1'b1);
      wait_done();

      // Random operations with corner-biased operands.
      for (int i = 0; i < 40; i++) begin
         rop = 2'($urandom_range(0, 3));
         ra  = $urandom;
         rb  = $urandom;
         case ($urandom_range(0, 7))
            0: rb = '0;
            1: rb = 32'($urandom_range(1, 15));
            2: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            3: ra = 32'($urandom_range(0, 255));
            default: ;
         endcase
         issue(rop, ra, rb, 1'($urandom_range(0, 1)), 1'b1);
         wait_done();
      end

      repeat (5) @(negedge clk);
      chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
      chk("final_hi", {32'd0, bus.hi}, {32'd0, m_hi});
      chk("final_lo", {32'd0, bus.lo}, {32'd0, m_lo});
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
